// File: rtl/ram4_pkg.sv
// ============================================================================
// Module      : ram4_pkg
// Description : Shared constants and FSM encoding for the ram4_bank block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram4_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } ram4_state_t;

    localparam logic [1:0] SWEEP_LAST = 2'd3;

endpackage : ram4_pkg

`default_nettype wire

// File: rtl/load_decode4.sv
// ============================================================================
// Module      : load_decode4
// Description : Combinational 1-to-4 demultiplexer turning a write strobe and
//               a 2-bit address into one-hot per-word load strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_decode4
    import ram4_pkg::*;
(
    input  logic       load_i,
    input  logic [1:0] address_i,
    output logic [3:0] ld_o
);

    always_comb begin
        ld_o = 4'b0000;
        if (load_i) begin
            case (address_i)
                2'd0:    ld_o = 4'b0001;
                2'd1:    ld_o = 4'b0010;
                2'd2:    ld_o = 4'b0100;
                default: ld_o = 4'b1000;
            endcase
        end
    end

endmodule : load_decode4

`default_nettype wire

// File: rtl/ram4_bank.sv
// ============================================================================
// Module      : ram4_bank
// Description : 4-word register bank with one-hot write decode, combinational
//               4:1 read mux and a 4-cycle clear sweep sequencer.
//               Optional write-through read forwarding: RAM4_BANK_READ_BYPASS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram4_bank
    import ram4_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [1:0]       address,
    input  logic             clear_start,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    ram4_state_t      state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [4];
    logic [WIDTH-1:0] mem_d [4];
    logic [3:0]       ld;

    load_decode4 u_load_decode4 (
        .load_i    (load),
        .address_i (address),
        .ld_o      (ld)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Sweep outranks writes: a clear request in IDLE drops a same-cycle load,
    // and loads or further clear requests during SWEEP are ignored.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            mem_d[i] = mem_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d = ST_SWEEP;
                    ptr_d   = 2'd0;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (ld[i]) begin
                            mem_d[i] = in;
                        end
                    end
                end
            end
            ST_SWEEP: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == SWEEP_LAST) begin
                    state_d = ST_IDLE;
                    ptr_d   = 2'd0;
                end else begin
                    ptr_d = ptr_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        out = mem_q[address];
`ifdef RAM4_BANK_READ_BYPASS_EN
        if ((state_q == ST_IDLE) && load && !clear_start) begin
            out = in;
        end
`endif
    end

    assign busy = (state_q == ST_SWEEP);

endmodule : ram4_bank

`default_nettype wire

// File: tb/tb_ram4_bank.sv
// ============================================================================
// Module      : tb_ram4_bank
// Description : Directed self-checking bench for ram4_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram4_bank;

    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             load;
    logic [1:0]       address;
    logic             clear_start;
    logic [WIDTH-1:0] out;
    logic             busy;

    int checks = 0;
    int errors = 0;

    ram4_bank #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in),
        .load        (load),
        .address     (address),
        .clear_start (clear_start),
        .out         (out),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_word(input logic [1:0] a, input logic [WIDTH-1:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] exp);
        for (int i = 0; i < 4; i++) begin
            address = 2'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), 32'(out), 32'(exp));
        end
    endtask

    logic [WIDTH-1:0] vals [4];

    initial begin
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333; vals[3] = 16'h4444;
        reset = 1'b1; in = '0; load = 1'b0; address = 2'd0; clear_start = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset with nonzero prior contents
        write_word(2'd0, 16'h1234);
        write_word(2'd3, 16'h5678);
        address = 2'd0; #1;
        check("pre_reset_w0", 32'(out), 32'h1234);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 32'h0);
        check_all("reset_out", 16'h0000);

        // Write all words; the old value is visible before each write edge
        for (int i = 0; i < 4; i++) begin
            address = 2'(i);
            in      = vals[i];
            load    = 1'b1;
            #1;
`ifdef RAM4_BANK_READ_BYPASS_EN
            check($sformatf("pre_write[%0d]", i), 32'(out), 32'(vals[i]));
`else
            check($sformatf("pre_write[%0d]", i), 32'(out), 32'h0);
`endif
            tick();
        end
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            address = 2'(i);
            #1;
            check($sformatf("readback[%0d]", i), 32'(out), 32'(vals[i]));
        end

        // Clear sweep over 0xAAAA contents
        for (int i = 0; i < 4; i++) write_word(2'(i), 16'hAAAA);
        clear_start = 1'b1;
        address     = 2'd3;
        #1;
        check("sweep_idle_busy", 32'(busy), 32'h0);
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            address = 2'd3;
            #1;
            check($sformatf("sweep_busy[%0d]", c), 32'(busy), 32'h1);
            check($sformatf("sweep_w3[%0d]", c), 32'(out), 32'hAAAA);
            tick();
        end
        check("sweep_done_busy", 32'(busy), 32'h0);
        check_all("sweep_clear", 16'h0000);

        // clear_start and load together: load dropped
        clear_start = 1'b1;
        load        = 1'b1;
        address     = 2'd1;
        in          = 16'h5555;
        tick();
        clear_start = 1'b0;
        load        = 1'b0;
        #1;
        check("coll_ld_drop", 32'(out), 32'h0);
        check("coll_busy0", 32'(busy), 32'h1);
        tick();
        clear_start = 1'b1;          // second request mid-sweep
        tick();
        clear_start = 1'b0;
        tick();
        load    = 1'b1;              // load during the final sweep cycle
        address = 2'd2;
        in      = 16'h7777;
        #1;
        check("coll_busy3", 32'(busy), 32'h1);
        tick();
        load = 1'b0;
        check("coll_no_restart", 32'(busy), 32'h0);
        address = 2'd2;
        #1;
        check("coll_ld_ignored", 32'(out), 32'h0);

        // Reset mid-sweep
        for (int i = 0; i < 4; i++) write_word(2'(i), 16'hAAAA);
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_sweep_busy", 32'(busy), 32'h0);
        check_all("rst_sweep_out", 16'h0000);
        tick();
        check("rst_sweep_idle", 32'(busy), 32'h0);
        write_word(2'd0, 16'h00FF);
        address = 2'd0;
        #1;
        check("rst_sweep_wr", 32'(out), 32'h00FF);

        // Forwarding behaviour on word2 (currently 0)
        address = 2'd2;
        in      = 16'hBEEF;
        load    = 1'b1;
        #1;
`ifdef RAM4_BANK_READ_BYPASS_EN
        check("bypass_same", 32'(out), 32'hBEEF);
`else
        check("no_bypass_same", 32'(out), 32'h0);
`endif
        tick();
        load = 1'b0;
        #1;
        check("bypass_stored", 32'(out), 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ram4_bank

`default_nettype wire
